// File: rtl/layer_seq_ctrl.sv
// Run-level sequencer for a single conv/pool layer instance.
// A run clears the layer and streams the WIDTH*WIDTH input map from the input
// buffer. It captures up to DOUT result words into the output buffer, then
// pulses done. A watchdog ends the drain phase if the layer stops producing.
module layer_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CH         = 32,
    parameter int unsigned WIDTH      = 7,
    parameter int unsigned DOUT       = 1,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned DIM = WIDTH * WIDTH,
    localparam int unsigned WW  = DATA_WIDTH * CH,
    localparam int unsigned IAW = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int unsigned OAW = (DOUT > 1) ? $clog2(DOUT) : 1,
    localparam int unsigned CW  = $clog2(DOUT + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err_timeout,
    output logic           out_ovf,
    output logic           in_rd_en,
    output logic [IAW-1:0] in_rd_addr,
    input  logic [WW-1:0]  in_rd_data,
    output logic           lyr_clr,
    output logic [WW-1:0]  lyr_data,
    output logic           lyr_valid,
    input  logic [WW-1:0]  lyr_out_data,
    input  logic           lyr_out_valid,
    output logic           out_wr_en,
    output logic [OAW-1:0] out_wr_addr,
    output logic [WW-1:0]  out_wr_data,
    output logic [CW-1:0]  out_count
);

    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    logic [WDW-1:0] wd;
    logic           capture_win;
    logic           room;
    logic           accept;
    logic           ovf_hit;
    logic           count_full;

    // Output capture window, write strobe, and read-data pass-through to the layer
    always_comb begin
        capture_win = (state == S_STREAM) || (state == S_DRAIN) || (state == S_DONE);
        room        = (out_count < CW'(DOUT));
        accept      = capture_win && lyr_out_valid && room;
        ovf_hit     = capture_win && lyr_out_valid && !room;
        // A result accepted this cycle already counts toward completion
        count_full  = (out_count == CW'(DOUT)) || (accept && (out_count == CW'(DOUT - 1)));
        out_wr_en   = accept;
        out_wr_addr = OAW'(out_count);
        out_wr_data = lyr_out_data;
        lyr_data    = in_rd_data;
    end

    // Sequencer FSM with registered control outputs, result counting and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            out_ovf     <= 1'b0;
            in_rd_en    <= 1'b0;
            in_rd_addr  <= '0;
            lyr_clr     <= 1'b0;
            lyr_valid   <= 1'b0;
            out_count   <= '0;
            wd          <= '0;
        end else begin
            done      <= 1'b0;
            lyr_clr   <= 1'b0;
            lyr_valid <= in_rd_en;
            if (accept) begin
                out_count <= out_count + CW'(1);
            end
            if (ovf_hit) begin
                out_ovf <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CLEAR;
                        lyr_clr     <= 1'b1;
                        busy        <= 1'b1;
                        err_timeout <= 1'b0;
                        out_ovf     <= 1'b0;
                        out_count   <= '0;
                        in_rd_addr  <= '0;
                    end
                end
                S_CLEAR: begin
                    state      <= S_STREAM;
                    in_rd_en   <= 1'b1;
                    in_rd_addr <= '0;
                end
                S_STREAM: begin
                    if (in_rd_addr == IAW'(DIM - 1)) begin
                        state    <= S_DRAIN;
                        in_rd_en <= 1'b0;
                        wd       <= '0;
                    end else begin
                        in_rd_addr <= in_rd_addr + IAW'(1);
                    end
                end
                S_DRAIN: begin
                    if (count_full && !lyr_valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (lyr_out_valid) begin
                        wd <= '0;
                    end else if (wd == WDW'(TIMEOUT - 1)) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed testbench for layer_seq_ctrl. The main instance uses DOUT=1 and TIMEOUT=64.
// The second instance uses DOUT=2. Cycle 0 is the cycle in which start is first high.
module tb_layer_seq_ctrl;

    localparam int W = 1024;

    logic         clk;
    logic         rst;
    int           checks;
    int           fails;

    logic         start, busy, done, err_timeout, out_ovf, in_rd_en, lyr_clr, lyr_valid;
    logic [5:0]   in_rd_addr;
    logic [W-1:0] in_rd_data, lyr_data, lyr_out_data, out_wr_data;
    logic         lyr_out_valid, out_wr_en;
    logic [0:0]   out_wr_addr;
    logic [0:0]   out_count;

    logic         start2, busy2, done2, err2, ovf2, in_rd_en2, lyr_clr2, lyr_valid2;
    logic [5:0]   in_rd_addr2;
    logic [W-1:0] in_rd_data2, lyr_data2, lyr_out_data2, out_wr_data2;
    logic         lyr_out_valid2, out_wr_en2;
    logic [0:0]   out_wr_addr2;
    logic [1:0]   out_count2;

    layer_seq_ctrl #(.DATA_WIDTH(32), .CH(32), .WIDTH(7), .DOUT(1), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_timeout(err_timeout), .out_ovf(out_ovf), .in_rd_en(in_rd_en),
        .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .lyr_clr(lyr_clr),
        .lyr_data(lyr_data), .lyr_valid(lyr_valid), .lyr_out_data(lyr_out_data),
        .lyr_out_valid(lyr_out_valid), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data), .out_count(out_count)
    );

    layer_seq_ctrl #(.DATA_WIDTH(32), .CH(32), .WIDTH(7), .DOUT(2), .TIMEOUT(1024)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .err_timeout(err2), .out_ovf(ovf2), .in_rd_en(in_rd_en2),
        .in_rd_addr(in_rd_addr2), .in_rd_data(in_rd_data2), .lyr_clr(lyr_clr2),
        .lyr_data(lyr_data2), .lyr_valid(lyr_valid2), .lyr_out_data(lyr_out_data2),
        .lyr_out_valid(lyr_out_valid2), .out_wr_en(out_wr_en2), .out_wr_addr(out_wr_addr2),
        .out_wr_data(out_wr_data2), .out_count(out_count2)
    );

    function automatic logic [W-1:0] pat(input int a);
        logic [W-1:0] r;
        logic [31:0]  v;
        v = 32'hC0DE0000 ^ 32'(a);
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = v + 32'(i * 7);
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input buffers: one-cycle read latency
    always @(posedge clk) begin
        if (in_rd_en)  in_rd_data  <= pat(int'(in_rd_addr));
        if (in_rd_en2) in_rd_data2 <= pat(int'(in_rd_addr2) + 100);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Finish whatever run is in progress: one layer output once streaming is over
    task automatic complete_run(input string name);
        bit sent;
        bit seen;
        sent = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            lyr_out_valid = busy && !in_rd_en && !lyr_valid && !lyr_clr && !sent;
            lyr_out_data  = pat(555);
            if (lyr_out_valid) sent = 1'b1;
        end
        lyr_out_valid = 1'b0;
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s complete_run: no done within 300 cycles", name);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1; start2 = 1'b1;
        lyr_out_valid = 1'b1; lyr_out_valid2 = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({busy, done, err_timeout, out_ovf, in_rd_en, in_rd_addr, lyr_clr, lyr_valid,
             out_wr_en, out_wr_addr, out_count} !== '0) begin
            fails++;
            $display("FAIL reset dut outputs not zero: busy=%b done=%b rd_en=%b addr=%0d clr=%b wr=%b cnt=%0d",
                     busy, done, in_rd_en, in_rd_addr, lyr_clr, out_wr_en, out_count);
        end
        checks++;
        if ({busy2, done2, err2, ovf2, in_rd_en2, in_rd_addr2, lyr_clr2, lyr_valid2,
             out_wr_en2, out_wr_addr2, out_count2} !== '0) begin
            fails++;
            $display("FAIL reset dut2 outputs not zero: busy=%b done=%b wr=%b cnt=%0d",
                     busy2, done2, out_wr_en2, out_count2);
        end
        rst = 1'b0;
        start = 1'b0; start2 = 1'b0;
        lyr_out_valid = 1'b0; lyr_out_valid2 = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        bit exp_rd, exp_lv;
        start = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            tick();
            start = 1'b0;
            lyr_out_valid = (c == 70);
            lyr_out_data  = pat(777);
            #1;
            exp_rd = (c >= 2 && c <= 50);
            exp_lv = (c >= 3 && c <= 51);
            checks++;
            if (in_rd_en !== exp_rd) begin
                fails++; $display("FAIL nominal in_rd_en c=%0d got %b exp %b", c, in_rd_en, exp_rd);
            end
            if (exp_rd) begin
                checks++;
                if (in_rd_addr !== 6'(c - 2)) begin
                    fails++; $display("FAIL nominal in_rd_addr c=%0d got %0d exp %0d", c, in_rd_addr, c - 2);
                end
            end
            checks++;
            if (lyr_valid !== exp_lv) begin
                fails++; $display("FAIL nominal lyr_valid c=%0d got %b exp %b", c, lyr_valid, exp_lv);
            end
            if (exp_lv) begin
                checks++;
                if (lyr_data !== pat(c - 3)) begin
                    fails++; $display("FAIL nominal lyr_data c=%0d got %h exp %h", c, lyr_data[31:0], pat(c - 3) & 32'hFFFFFFFF);
                end
            end
            checks++;
            if (lyr_clr !== (c == 1)) begin
                fails++; $display("FAIL nominal lyr_clr c=%0d got %b", c, lyr_clr);
            end
            checks++;
            if (done !== (c == 71)) begin
                fails++; $display("FAIL nominal done c=%0d got %b", c, done);
            end
            checks++;
            if (busy !== (c <= 71)) begin
                fails++; $display("FAIL nominal busy c=%0d got %b", c, busy);
            end
            checks++;
            if (out_wr_en !== (c == 70)) begin
                fails++; $display("FAIL nominal out_wr_en c=%0d got %b", c, out_wr_en);
            end
            if (c == 70) begin
                checks++;
                if (out_wr_addr !== 1'b0 || out_wr_data !== pat(777)) begin
                    fails++; $display("FAIL nominal write addr=%0d data=%h exp addr 0 data %h",
                                      out_wr_addr, out_wr_data[31:0], pat(777) & 32'hFFFFFFFF);
                end
            end
            if (c == 71) begin
                checks++;
                if (out_count !== 1'b1 || err_timeout !== 1'b0) begin
                    fails++; $display("FAIL nominal end out_count=%0d exp 1 err_timeout=%b exp 0", out_count, err_timeout);
                end
            end
        end
        lyr_out_valid = 1'b0;
    endtask

    task automatic test_timeout();
        start = 1'b1;
        for (int c = 1; c <= 117; c++) begin
            tick();
            start = (c == 116);
            #1;
            checks++;
            if (done !== (c == 115)) begin
                fails++; $display("FAIL timeout done c=%0d got %b", c, done);
            end
            checks++;
            if (out_wr_en !== 1'b0) begin
                fails++; $display("FAIL timeout out_wr_en c=%0d got %b exp 0", c, out_wr_en);
            end
            if (c == 115) begin
                checks++;
                if (err_timeout !== 1'b1 || out_count !== 1'b0) begin
                    fails++; $display("FAIL timeout flag err_timeout=%b exp 1 out_count=%0d exp 0", err_timeout, out_count);
                end
            end
            if (c == 116) begin
                checks++;
                if (busy !== 1'b0 || err_timeout !== 1'b1) begin
                    fails++; $display("FAIL timeout idle busy=%b exp 0 err_timeout=%b exp 1", busy, err_timeout);
                end
            end
            if (c == 117) begin
                checks++;
                if (err_timeout !== 1'b0 || lyr_clr !== 1'b1) begin
                    fails++; $display("FAIL timeout restart err_timeout=%b exp 0 lyr_clr=%b exp 1", err_timeout, lyr_clr);
                end
            end
        end
        start = 1'b0;
        complete_run("timeout");
    endtask

    task automatic test_overflow();
        int ndone;
        ndone = 0;
        start = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            tick();
            start = 1'b0;
            lyr_out_valid = (c >= 20 && c <= 22);
            lyr_out_data  = pat(900 + c);
            #1;
            if (done) ndone++;
            checks++;
            if (out_wr_en !== (c == 20)) begin
                fails++; $display("FAIL overflow out_wr_en c=%0d got %b", c, out_wr_en);
            end
            if (c == 20) begin
                checks++;
                if (out_wr_addr !== 1'b0 || out_wr_data !== pat(920)) begin
                    fails++; $display("FAIL overflow write addr=%0d exp 0 data=%h", out_wr_addr, out_wr_data[31:0]);
                end
            end
            checks++;
            if (out_ovf !== (c >= 22)) begin
                fails++; $display("FAIL overflow out_ovf c=%0d got %b exp %b", c, out_ovf, c >= 22);
            end
            if (c == 53) begin
                checks++;
                if (done !== 1'b1 || out_count !== 1'b1) begin
                    fails++; $display("FAIL overflow end done=%b exp 1 out_count=%0d exp 1", done, out_count);
                end
            end
        end
        lyr_out_valid = 1'b0;
        checks++;
        if (ndone != 1) begin
            fails++; $display("FAIL overflow done pulses got %0d exp 1", ndone);
        end
    endtask

    task automatic test_reset_midstream();
        int  nvalid;
        bit  sent;
        bit  seen;
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (in_rd_addr !== 6'd20) begin
            fails++; $display("FAIL midreset addr before reset got %0d exp 20", in_rd_addr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (in_rd_en !== 1'b0 || lyr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL midreset abort rd_en=%b lyr_valid=%b busy=%b done=%b exp all 0",
                              in_rd_en, lyr_valid, busy, done);
        end
        rst = 1'b0;
        start = 1'b1;
        nvalid = 0;
        sent = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == 1) begin
                checks++;
                if (in_rd_en !== 1'b1 || in_rd_addr !== 6'd0) begin
                    fails++; $display("FAIL midreset restart rd_en=%b addr=%0d exp 1 and 0", in_rd_en, in_rd_addr);
                end
            end
            if (lyr_valid) begin
                checks++;
                if (lyr_data !== pat(nvalid)) begin
                    fails++; $display("FAIL midreset lyr_data word %0d got %h", nvalid, lyr_data[31:0]);
                end
                nvalid++;
            end
            lyr_out_valid = busy && !in_rd_en && !lyr_valid && !lyr_clr && !sent;
            lyr_out_data  = pat(321);
            if (lyr_out_valid) sent = 1'b1;
        end
        lyr_out_valid = 1'b0;
        checks++;
        if (!seen || nvalid != 49) begin
            fails++; $display("FAIL midreset rerun done_seen=%b words=%0d exp 1 and 49", seen, nvalid);
        end
        tick();
    endtask

    task automatic test_start_held();
        start = 1'b1;
        for (int c = 1; c <= 74; c++) begin
            tick();
            lyr_out_valid = (c == 70);
            lyr_out_data  = pat(42);
            #1;
            checks++;
            if (lyr_clr !== (c == 1 || c == 73)) begin
                fails++; $display("FAIL start_held lyr_clr c=%0d got %b", c, lyr_clr);
            end
            checks++;
            if (done !== (c == 71)) begin
                fails++; $display("FAIL start_held done c=%0d got %b", c, done);
            end
            if (c == 72) begin
                checks++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL start_held idle busy got %b exp 0", busy);
                end
            end
        end
        lyr_out_valid = 1'b0;
        start = 1'b0;
        complete_run("start_held");
    endtask

    task automatic test_dout2();
        start2 = 1'b1;
        for (int c = 1; c <= 63; c++) begin
            tick();
            start2 = 1'b0;
            lyr_out_valid2 = (c == 30 || c == 60);
            lyr_out_data2  = pat(2000 + c);
            #1;
            checks++;
            if (out_wr_en2 !== (c == 30 || c == 60)) begin
                fails++; $display("FAIL dout2 out_wr_en c=%0d got %b", c, out_wr_en2);
            end
            if (c == 30 || c == 60) begin
                checks++;
                if (out_wr_addr2 !== ((c == 60) ? 1'b1 : 1'b0) || out_wr_data2 !== pat(2000 + c)) begin
                    fails++; $display("FAIL dout2 write c=%0d addr=%0d exp %0d data=%h",
                                      c, out_wr_addr2, (c == 60), out_wr_data2[31:0]);
                end
            end
            checks++;
            if (done2 !== (c == 61)) begin
                fails++; $display("FAIL dout2 done c=%0d got %b", c, done2);
            end
            if (c == 61) begin
                checks++;
                if (out_count2 !== 2'd2 || err2 !== 1'b0) begin
                    fails++; $display("FAIL dout2 end out_count=%0d exp 2 err=%b exp 0", out_count2, err2);
                end
            end
        end
        lyr_out_valid2 = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b0;
        start = 1'b0; start2 = 1'b0;
        lyr_out_valid = 1'b0; lyr_out_valid2 = 1'b0;
        lyr_out_data = '0; lyr_out_data2 = '0;
        in_rd_data = '0; in_rd_data2 = '0;
        test_reset();
        test_nominal();
        test_timeout();
        test_overflow();
        test_reset_midstream();
        test_start_held();
        test_dout2();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
Run-level sequencer for one VGG16 conv/pool layer instance such as layer13_1. On a start pulse it clears the layer, streams the full WIDTH*WIDTH input feature map from an input buffer into the layer with valid, captures DOUT result words into an output buffer, then signals done. A watchdog flags layers that stall without producing their outputs.

Parameters:
DATA_WIDTH, 32, bits per channel value
CH, 32, channels packed per word (word width = DATA_WIDTH*CH)
WIDTH, 7, input feature map side; DIM = WIDTH*WIDTH words per run
DOUT, 1, result words expected per run
TIMEOUT, 1024, maximum idle cycles in DRAIN between outputs

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request, sampled only in IDLE
busy  out  1  high from CLEAR through DONE
done  out  1  one-cycle pulse at end of run
err_timeout  out  1  sticky watchdog error, cleared on accepted start
out_ovf  out  1  sticky, more than DOUT outputs seen, cleared on accepted start
in_rd_en  out  1  input buffer read strobe
in_rd_addr  out  max(1,clog2(DIM))  input buffer address
in_rd_data  in  DATA_WIDTH*CH  input buffer data, valid 1 cycle after in_rd_en
lyr_clr  out  1  one-cycle layer clear
lyr_data  out  DATA_WIDTH*CH  layer i_data
lyr_valid  out  1  layer valid_in
lyr_out_data  in  DATA_WIDTH*CH  layer o_data
lyr_out_valid  in  1  layer valid_out
out_wr_en  out  1  output buffer write strobe
out_wr_addr  out  max(1,clog2(DOUT))  output buffer address
out_wr_data  out  DATA_WIDTH*CH  output buffer data
out_count  out  clog2(DOUT+1)  results written this run

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, flags, in_rd_en, in_rd_addr, lyr_clr, lyr_valid, out_wr_en, out_wr_addr, out_count. All counters 0. rst overrides start and lyr_out_valid in the same cycle. Reset mid-run aborts immediately with no done pulse.
- FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at edge N gives CLEAR in cycle N+1. At that edge, err_timeout, out_ovf, out_count and addresses are cleared. start in any other state is ignored.
- CLEAR, 1 cycle: lyr_clr=1, busy=1.
- STREAM, DIM cycles: in_rd_en=1, in_rd_addr runs 0..DIM-1 with one increment per cycle and no gaps. The last address goes to DRAIN.
- Read pipeline: lyr_valid is in_rd_en delayed 1 cycle. lyr_data = in_rd_data, combinational and unregistered. Exactly DIM lyr_valid cycles per run.
- Output capture, in STREAM, DRAIN and DONE:
  - On each lyr_out_valid with out_count<DOUT, out_wr_en=1 in the same cycle (combinational), with out_wr_data=lyr_out_data and out_wr_addr=out_count. out_count increments at the edge.
  - With out_count==DOUT, the write is suppressed and out_ovf is set.
  - lyr_out_valid in IDLE or CLEAR is ignored.
- DRAIN:
  - Watchdog counter resets on entry and on every lyr_out_valid, otherwise increments.
  - Exit to DONE when out_count==DOUT and lyr_valid==0. An output accepted in the current cycle counts.
  - If the watchdog reaches TIMEOUT-1 without this, err_timeout=1 and go to DONE.
- DONE, 1 cycle: done=1, busy=1. The next cycle is IDLE with busy=0. A new start is accepted from the first IDLE cycle.
- Output of an address decoded as out_count uses out_count before increment. No wrap within a run.

Test Plan:
1. Nominal (DIM=49, DOUT=1): start at cycle 0.
   - lyr_clr at cycle 1.
   - in_rd_addr 0..48 at cycles 2..50.
   - lyr_valid at cycles 3..51.
   - Model raises lyr_out_valid at cycle 70 -> out_wr_en at 70 with addr 0 and data matching, out_count=1, done at 71, busy=0 at 72, err_timeout=0.
2. Timeout (TIMEOUT=64): model never responds. DRAIN is entered at cycle 51 -> done at cycle 115, err_timeout=1, out_count=0, out_wr_en never asserted. A subsequent start clears err_timeout.
3. Overflow: model emits 3 valid_out pulses -> a single write to addr 0, out_ovf=1, out_count=1, done still pulses once.
4. Reset mid-stream: rst at in_rd_addr=20 -> next cycle in_rd_en=0, lyr_valid=0, busy=0, no done. A new start re-streams from addr 0, and all 49 words are delivered.
5. start held high continuously -> exactly one run per IDLE entry. Starts during CLEAR/STREAM/DRAIN/DONE are ignored, and the second run's CLEAR is 2 cycles after done.
6. DOUT=2, model outputs at cycle 30 (during STREAM) and cycle 60 -> writes to addr 0 then 1, done at 61.
